// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int         XLEN_DEF    = 32;
    localparam int         TIMEOUT_DEF = 255;
    localparam logic [3:0] BE_ALL      = 4'hF;

    // BUSY_x: request on the bus, waiting for grant.
    // WAIT_x: granted, waiting for response/ack.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_D = 3'd1,
        WAIT_D = 3'd2,
        BUSY_I = 3'd3,
        WAIT_I = 3'd4
    } arb_state_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating cycle counter used to detect an overdue memory response.
module arb_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int           W       = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    // Count enabled cycles, holding at LIMIT once reached.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT_W)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and
// data load/store. Data wins; one transaction outstanding at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_reqF,
    input  logic [XLEN-1:0] pcF,
    input  logic            flushD,
    input  logic            pipe_advF,
    output logic [31:0]     instrF,
    output logic            fetch_stall,
    input  logic            mem_rdM,
    input  logic            mem_wrM,
    input  logic [XLEN-1:0] addrM,
    input  logic [31:0]     wdataM,
    input  logic [3:0]      byte_enM,
    input  logic            pipe_advM,
    output logic [31:0]     rdataM,
    output logic            mem_stall,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_be,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [31:0]     m_rdata,
    output logic            err_timeout
);

    arb_state_t      state_q, state_d;
    logic            m_we_q, m_we_d;
    logic [XLEN-1:0] m_addr_q, m_addr_d;
    logic [31:0]     m_wdata_q, m_wdata_d;
    logic [3:0]      m_be_q, m_be_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            i_done_q, i_done_d;
    logic            d_done_q, d_done_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;
    logic            timer_clear, timer_en, timer_expired;

    logic data_req;
    assign data_req = mem_rdM | mem_wrM;

    arb_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state, payload capture and completion handling.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
        state_d     = state_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_be_d      = m_be_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        drop_d      = drop_q;
        timer_clear = 1'b0;
        timer_en    = (state_q == WAIT_D) || (state_q == WAIT_I);
        err_d       = err_q | timer_expired;

        // Served accesses are released once the owning stage moves on.
        if (pipe_advF || flushD) i_done_d = 1'b0;
        if (pipe_advM)           d_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_req && !d_done_q) begin
                    state_d   = BUSY_D;
                    m_addr_d  = addrM;
                    m_wdata_d = wdataM;
                    m_we_d    = mem_wrM;  // load+store together acts as a store
                    m_be_d    = mem_wrM ? byte_enM : BE_ALL;
                end else if (fetch_reqF && !i_done_q && !flushD) begin
                    state_d  = BUSY_I;
                    m_addr_d = pcF;
                    m_we_d   = 1'b0;
                    m_be_d   = BE_ALL;
                end
            end
            BUSY_D, BUSY_I: begin
                if (m_gnt) begin
                    state_d     = (state_q == BUSY_D) ? WAIT_D : WAIT_I;
                    timer_clear = 1'b1;
                end
            end
            WAIT_D: begin
                if (m_rvalid) begin
                    state_d  = IDLE;
                    rdata_d  = m_rdata;
                    d_done_d = 1'b1;
                end
            end
            WAIT_I: begin
                if (m_rvalid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flushD)) begin
                        instr_d  = m_rdata;
                        i_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A squashed fetch still has to complete on the bus; remember to discard it.
        if (flushD && ((state_q == BUSY_I) || ((state_q == WAIT_I) && !m_rvalid))) begin
            drop_d = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register has an asynchronous reset so an abandoned transaction leaves no stale request.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so all registers update from the same pre-edge values.
            state_q <= state_d;
        end
    end

    // Bus payload, result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            instr_q   <= '0;
            rdata_q   <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    assign m_req       = (state_q == BUSY_D) || (state_q == BUSY_I);
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign m_be        = m_be_q;
    assign instrF      = instr_q;
    assign rdataM      = rdata_q;
    assign err_timeout = err_q;
    assign fetch_stall = fetch_reqF & ~i_done_q;
    assign mem_stall   = data_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized fetch/load/store mixes against a word-array memory model.
module tb_mem_port_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_reqF = 1'b0, flushD = 1'b0, pipe_advF = 1'b0;
    logic [XLEN-1:0] pcF = '0;
    logic [31:0]     instrF;
    logic            fetch_stall;
    logic            mem_rdM = 1'b0, mem_wrM = 1'b0, pipe_advM = 1'b0;
    logic [XLEN-1:0] addrM = '0;
    logic [31:0]     wdataM = '0;
    logic [3:0]      byte_enM = '0;
    logic [31:0]     rdataM;
    logic            mem_stall;
    logic            m_req, m_we;
    logic [XLEN-1:0] m_addr;
    logic [31:0]     m_wdata;
    logic [3:0]      m_be;
    logic            m_gnt;
    logic            m_rvalid;
    logic [31:0]     m_rdata;
    logic            err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_reqF(fetch_reqF), .pcF(pcF), .flushD(flushD), .pipe_advF(pipe_advF),
        .instrF(instrF), .fetch_stall(fetch_stall),
        .mem_rdM(mem_rdM), .mem_wrM(mem_wrM), .addrM(addrM), .wdataM(wdataM),
        .byte_enM(byte_enM), .pipe_advM(pipe_advM), .rdataM(rdataM), .mem_stall(mem_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- memory model (bus slave) ----------------
    int          gnt_delay = 0;
    int          rv_delay  = 1;
    bit          hang      = 1'b0;
    int          gwait, rleft, n_txn = 0;
    bit          pend;
    logic [31:0] p_data;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] txn_addr[$];

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h0050_0093;
        if (i == 24) return 32'h1234_5678;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign m_gnt = m_req && (gwait >= gnt_delay);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gwait    <= 0;
            rleft    <= 0;
            pend     <= 1'b0;
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else begin
            m_rvalid <= 1'b0;
            if (m_gnt) begin
                gwait <= 0;
                n_txn <= n_txn + 1;
                txn_addr.push_back(m_addr);
                if (m_we) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mem[m_addr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
                end
                p_data <= m_we ? 32'h0 : mem[m_addr[11:2]];
                if (!hang && rv_delay <= 1) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= m_we ? 32'h0 : mem[m_addr[11:2]];
                end else begin
                    pend  <= 1'b1;
                    rleft <= rv_delay - 1;
                end
            end else begin
                if (m_req) gwait <= gwait + 1;
                if (pend && !hang) begin
                    if (rleft <= 1) begin
                        m_rvalid <= 1'b1;
                        m_rdata  <= p_data;
                        pend     <= 1'b0;
                    end else begin
                        rleft <= rleft - 1;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic init_ref();
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    int cyc_d, cyc_f, cyc_all;

    // Present one pipeline request set, wait until no stall, then advance the pipeline.
    task automatic run_txn(input bit f, input logic [31:0] pc, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input bit chk_pl);
        bit timed_out;
        fetch_reqF = f;  pcF = pc;  mem_rdM = rd;  mem_wrM = wr;
        addrM = a;  wdataM = wd;  byte_enM = be;
        cyc_d = 0;  cyc_f = 0;  cyc_all = 0;  timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc_all++;
            if (chk_pl && m_req) begin
                check("payload_addr", m_addr, a);
                check("payload_we", 32'(m_we), 32'(wr));
                check("payload_be", 32'(m_be), wr ? 32'(be) : 32'hF);
                if (wr) check("payload_wdata", m_wdata, wd);
            end
            if (cyc_d == 0 && !mem_stall)   cyc_d = cyc_all;
            if (cyc_f == 0 && !fetch_stall) cyc_f = cyc_all;
            if (!mem_stall && !fetch_stall) break;
            if (cyc_all >= 400) begin
                timed_out = 1'b1;
                break;
            end
        end
        check("txn_timeout", 32'(timed_out), 32'h0);
        pipe_advF = 1'b1;  pipe_advM = 1'b1;
        @(negedge clk);
        pipe_advF = 1'b0;  pipe_advM = 1'b0;
        fetch_reqF = 1'b0; mem_rdM = 1'b0;  mem_wrM = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] last_instr, exp_load, exp_instr, a, pc, wd;
    logic [9:0]  di, pi;
    logic [3:0]  be;
    int          n0, kind;
    bit          f, rd, wr, nd;

    initial begin
        init_ref();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_req", 32'(m_req), 32'h0);
        check("rst_m_we", 32'(m_we), 32'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        check("rst_m_be", 32'(m_be), 32'h0);
        check("rst_instrF", instrF, 32'h0);
        check("rst_rdataM", rdataM, 32'h0);
        check("rst_err", 32'(err_timeout), 32'h0);
        check("rst_stalls", {30'h0, fetch_stall, mem_stall}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: fetch only, zero-wait memory
        n0 = n_txn;
        run_txn(1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("t1_latency", 32'(cyc_f), 32'd3);
        check("t1_instr", instrF, 32'h0050_0093);
        check("t1_ntxn", 32'(n_txn - n0), 32'd1);

        // 2: load + fetch together, data first
        n0 = n_txn;
        run_txn(1, 32'h44, 1, 0, 32'h100, 0, 0, 0);
        check("t2_mem_stall_cyc", 32'(cyc_d), 32'd3);
        check("t2_fetch_stall_cyc", 32'(cyc_f), 32'd6);
        check("t2_ntxn", 32'(n_txn - n0), 32'd2);
        check("t2_first_addr", txn_addr[txn_addr.size()-2], 32'h100);
        check("t2_second_addr", txn_addr[txn_addr.size()-1], 32'h44);
        check("t2_rdata", rdataM, ref_mem[64]);
        check("t2_instr", instrF, ref_mem[17]);
        last_instr = ref_mem[17];

        // 3: store with grant delayed 3 cycles
        gnt_delay = 3;
        n0 = n_txn;
        run_txn(0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1);
        ref_mem[128] = apply_be(ref_mem[128], 32'hDEAD_BEEF, 4'b0011);
        check("t3_ntxn", 32'(n_txn - n0), 32'd1);
        check("t3_latency", 32'(cyc_all), 32'd6);
        gnt_delay = 0;
        run_txn(0, 0, 1, 0, 32'h200, 0, 0, 1);
        check("t3_readback", rdataM, ref_mem[128]);

        // 4: flushD while fetch waits for its response
        rv_delay = 2;
        n0 = n_txn;
        fetch_reqF = 1'b1;  pcF = 32'h60;
        @(negedge clk);                 // BUSY_I
        @(negedge clk);                 // WAIT_I, response one cycle away
        flushD = 1'b1;  pcF = 32'h80;
        @(negedge clk);
        flushD = 1'b0;
        @(negedge clk);                 // squashed response consumed
        check("t4_instr_kept", instrF, last_instr);
        check("t4_not_done", 32'(fetch_stall), 32'h1);
        rv_delay = 1;
        run_txn(1, 32'h80, 0, 0, 0, 0, 0, 0);
        check("t4_refetch_latency", 32'(cyc_f), 32'd3);
        check("t4_refetch_instr", instrF, ref_mem[32]);
        check("t4_ntxn", 32'(n_txn - n0), 32'd2);
        check("t4_refetch_addr", txn_addr[txn_addr.size()-1], 32'h80);
        last_instr = ref_mem[32];

        // Randomized mixes
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 5);
            f  = (kind == 0) || (kind == 3) || (kind == 4);
            rd = (kind == 1) || (kind == 3) || (kind == 5);
            wr = (kind == 2) || (kind == 4) || (kind == 5);
            nd = rd | wr;
            di = 10'($urandom);
            pi = ((kind == 4) && $urandom_range(0, 1) == 1) ? di : 10'($urandom);
            a  = {20'h0, di, 2'b00};
            pc = {20'h0, pi, 2'b00};
            wd = $urandom;
            be = 4'($urandom);
            gnt_delay = $urandom_range(0, 3);
            rv_delay  = $urandom_range(1, 3);
            exp_load = ref_mem[di];
            if (wr) ref_mem[di] = apply_be(ref_mem[di], wd, be);
            exp_instr = ref_mem[pi];
            n0 = n_txn;
            run_txn(f, pc, rd, wr, a, wd, be, !f && nd);
            check("rnd_ntxn", 32'(n_txn - n0), 32'(int'(nd) + int'(f)));
            check("rnd_latency", 32'(cyc_all),
                  32'((int'(nd) + int'(f)) * (gnt_delay + rv_delay + 2)));
            if (rd && !wr) check("rnd_load", rdataM, exp_load);
            if (f) begin
                check("rnd_fetch", instrF, exp_instr);
                last_instr = exp_instr;
            end
            if (nd && f) begin
                check("rnd_data_first", 32'(cyc_d < cyc_f), 32'h1);
                check("rnd_order", txn_addr[txn_addr.size()-2], a);
            end
        end
        check("rnd_no_err", 32'(err_timeout), 32'h0);

        // 5: response never arrives -> sticky timeout
        gnt_delay = 0;  rv_delay = 1;  hang = 1'b1;
        mem_rdM = 1'b1;  addrM = 32'h300;
        repeat (200) @(negedge clk);
        check("t5_err_early", 32'(err_timeout), 32'h0);
        check("t5_stalled", 32'(mem_stall), 32'h1);
        repeat (60) @(negedge clk);
        check("t5_err_set", 32'(err_timeout), 32'h1);
        mem_rdM = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_err_sticky", 32'(err_timeout), 32'h1);
        check("t5_no_reissue", 32'(m_req), 32'h0);
        rst_n = 1'b0;
        #1;
        check("t5_err_cleared", 32'(err_timeout), 32'h0);
        hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        init_ref();
        @(negedge clk);

        // 6: reset while the data request waits for grant
        gnt_delay = 5;
        mem_rdM = 1'b1;  addrM = 32'h100;
        @(negedge clk);
        check("t6_req_up", 32'(m_req), 32'h1);
        rst_n = 1'b0;  mem_rdM = 1'b0;
        #1;
        check("t6_req_drop", 32'(m_req), 32'h0);
        check("t6_stalls", {30'h0, fetch_stall, mem_stall}, 32'h0);
        check("t6_addr_rst", m_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;  gnt_delay = 0;
        init_ref();
        @(negedge clk);
        n0 = n_txn;
        run_txn(1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("t6_fetch_latency", 32'(cyc_f), 32'd3);
        check("t6_fetch_instr", instrF, 32'h0050_0093);
        check("t6_ntxn", 32'(n_txn - n0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
